// File: rtl/toggle_hs_pkg.sv
// rtl/toggle_hs_pkg.sv - shared types and defaults for the toggle handshake receiver
package toggle_hs_pkg;

    typedef enum logic {
        TH_IDLE = 1'b0,
        TH_HOLD = 1'b1
    } th_state_e;

    localparam int TH_DATA_W      = 8;
    localparam int TH_SYNC_STAGES = 2;
    localparam int TH_CNT_W       = 16;

endpackage

// File: rtl/toggle_hs_rx_if.sv
// rtl/toggle_hs_rx_if.sv - sender link and consumer stream signals; evt_cnt present with TOGGLE_HS_RX_CNT_EN
interface toggle_hs_rx_if
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W = TH_DATA_W
);
    logic              req_tgl;
    logic [DATA_W-1:0] data_in;
    logic              ack_tgl;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              ready;
    logic              err;
`ifdef TOGGLE_HS_RX_CNT_EN
    logic [TH_CNT_W-1:0] evt_cnt;
`endif

    modport slave (
        input  req_tgl, data_in, ready,
`ifdef TOGGLE_HS_RX_CNT_EN
        output evt_cnt,
`endif
        output ack_tgl, dout, valid, err
    );

    modport master (
        output req_tgl, data_in, ready,
`ifdef TOGGLE_HS_RX_CNT_EN
        input  evt_cnt,
`endif
        input  ack_tgl, dout, valid, err
    );

endinterface

// File: rtl/tgl_sync.sv
// rtl/tgl_sync.sv - request toggle synchronizer with last-seen level edge detect
module tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_tgl,
    input  logic seen_upd,
    output logic req_sync,
    output logic req_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   seen_q, seen_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            seen_q <= seen_d;
        end
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], req_tgl};
        req_sync = sync_q[SYNC_STAGES-1];
        // Any level change is a new request; polarity carries no meaning
        req_edge = req_sync != seen_q;
        seen_d   = seen_upd ? req_sync : seen_q;
    end

endmodule

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - toggle handshake receiver to valid/ready; TOGGLE_HS_RX_CNT_EN adds evt_cnt
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = TH_DATA_W,
    parameter int SYNC_STAGES = TH_SYNC_STAGES
) (
    input  logic           clk,
    input  logic           reset,
    toggle_hs_rx_if.slave  bus
);

    th_state_e         state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              seen_upd;
    logic              req_edge;
    logic              req_sync_unused;
    logic              accept;
`ifdef TOGGLE_HS_RX_CNT_EN
    logic [TH_CNT_W-1:0] cnt_q, cnt_d;
`endif

    tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .req_tgl  (bus.req_tgl),
        .seen_upd (seen_upd),
        .req_sync (req_sync_unused),
        .req_edge (req_edge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TH_IDLE;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef TOGGLE_HS_RX_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef TOGGLE_HS_RX_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign accept = valid_q & bus.ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TH_IDLE: if (req_edge) state_d = TH_HOLD;
            TH_HOLD: if (accept)   state_d = TH_IDLE;
            default:               state_d = TH_IDLE;
        endcase
    end

    always_comb begin
        dout_d   = dout_q;
        valid_d  = valid_q;
        ack_d    = ack_q;
        err_d    = err_q;
        seen_upd = 1'b0;
`ifdef TOGGLE_HS_RX_CNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            TH_IDLE: begin
                if (req_edge) begin
                    dout_d   = bus.data_in;
                    valid_d  = 1'b1;
                    seen_upd = 1'b1;
                end
            end
            TH_HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
`ifdef TOGGLE_HS_RX_CNT_EN
                    cnt_d   = cnt_q + TH_CNT_W'(1);
`endif
                end
                // Sender toggled again before our ack: flag it, swallow the edge
                if (req_edge) begin
                    err_d    = 1'b1;
                    seen_upd = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.dout    = dout_q;
    assign bus.valid   = valid_q;
    assign bus.ack_tgl = ack_q;
    assign bus.err     = err_q;
`ifdef TOGGLE_HS_RX_CNT_EN
    assign bus.evt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - scoreboard bench for toggle_hs_rx, optional TOGGLE_HS_RX_CNT_EN
module tb_toggle_hs_rx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    toggle_hs_rx_if #(.DATA_W(8)) bus ();

    toggle_hs_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic        exp_ack = 1'b0;
    int          exp_cnt = 0;
    bit          mon_en = 1'b0;
    bit          ready_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack_flip();
        logic prev;
        bit   seen;
        prev = bus.ack_tgl;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (bus.ack_tgl !== prev) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (bus.valid === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit push, input bit do_wait);
        tick();
        bus.data_in = d;
        bus.req_tgl = ~bus.req_tgl;
        if (push) exp_q.push_back(d);
        if (do_wait) wait_ack_flip();
    endtask

    // Monitor: compare each accepted word and the resulting ack/count
    always @(negedge clk) begin
        if (mon_en && reset) begin
            chk("ack_tgl", {31'd0, bus.ack_tgl}, {31'd0, exp_ack});
`ifdef TOGGLE_HS_RX_CNT_EN
            chk("evt_cnt", {16'd0, bus.evt_cnt}, exp_cnt & 32'hFFFF);
`endif
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, bus.dout}, 32'hFFFF_FFFF);
                end else begin
                    chk("dout", {24'd0, bus.dout}, {24'd0, exp_q.pop_front()});
                end
                exp_ack = ~exp_ack;
                exp_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (ready_rand) begin
            #2;
            bus.ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_tgl = 1'b0;
        bus.data_in = 8'h00;
        bus.ready   = 1'b0;

        // Reset and idle
        repeat (3) tick();
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_ack", {31'd0, bus.ack_tgl}, 32'd0);
        chk("rst_dout", {24'd0, bus.dout}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", {31'd0, bus.valid}, 32'd0);
        end

        // Latency: valid after the third edge, ack on the fourth
        bus.ready = 1'b1;
        tick();
        bus.data_in = 8'hA5;
        bus.req_tgl = 1'b1;
        exp_q.push_back(8'hA5);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("lat_valid_e%0d", e), {31'd0, bus.valid}, (e == 3) ? 32'd1 : 32'd0);
        end
        chk("lat_dout", {24'd0, bus.dout}, 32'hA5);
        tick();
        chk("lat_ack", {31'd0, bus.ack_tgl}, 32'd1);
        chk("lat_valid_drop", {31'd0, bus.valid}, 32'd0);

        // Consumer stall
        bus.ready = 1'b0;
        send(8'h3C, 1'b1, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", {31'd0, bus.valid}, 32'd1);
            chk("stall_dout", {24'd0, bus.dout}, 32'h3C);
            chk("stall_ack", {31'd0, bus.ack_tgl}, 32'd1);
        end
        bus.ready = 1'b1;
        wait_ack_flip();
        bus.ready = 1'b0;
        repeat (5) tick();
        chk("stall_single_flip", {31'd0, bus.ack_tgl}, 32'd0);
        chk("stall_valid_low", {31'd0, bus.valid}, 32'd0);

        // Protocol violation while holding a word
        send(8'h5A, 1'b1, 1'b0);
        wait_valid();
        send(8'hFF, 1'b0, 1'b0);
        repeat (5) tick();
        chk("viol_err", {31'd0, bus.err}, 32'd1);
        chk("viol_dout", {24'd0, bus.dout}, 32'h5A);
        chk("viol_valid", {31'd0, bus.valid}, 32'd1);
        bus.ready = 1'b1;
        wait_ack_flip();
        bus.ready = 1'b0;
        repeat (6) tick();
        chk("viol_no_capture", {31'd0, bus.valid}, 32'd0);
        chk("viol_err_sticky", {31'd0, bus.err}, 32'd1);

        // Asynchronous reset while a word is held
        send(8'h77, 1'b1, 1'b0);
        wait_valid();
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset = 1'b0;
        bus.req_tgl = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.valid}, 32'd0);
        chk("arst_dout", {24'd0, bus.dout}, 32'd0);
        chk("arst_ack", {31'd0, bus.ack_tgl}, 32'd0);
        chk("arst_err", {31'd0, bus.err}, 32'd0);
`ifdef TOGGLE_HS_RX_CNT_EN
        chk("arst_cnt", {16'd0, bus.evt_cnt}, 32'd0);
`endif
        exp_q.delete();
        exp_ack = 1'b0;
        exp_cnt = 0;
        repeat (2) tick();
        reset = 1'b1;
        mon_en = 1'b1;

        // Eight back-to-back words
        bus.ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(i), 1'b1, 1'b1);
        repeat (3) tick();
        chk("b2b_ack", {31'd0, bus.ack_tgl}, 32'd0);
        chk("b2b_err", {31'd0, bus.err}, 32'd0);
        chk("b2b_drain", exp_q.size(), 32'd0);
`ifdef TOGGLE_HS_RX_CNT_EN
        chk("b2b_cnt", {16'd0, bus.evt_cnt}, 32'd8);
`endif

        // Randomized words with random consumer back-pressure
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        ready_rand = 1'b0;
        tick();
        bus.ready = 1'b0;
        repeat (3) tick();
        chk("rand_drain", exp_q.size(), 32'd0);
        chk("rand_err", {31'd0, bus.err}, 32'd0);
        chk("rand_valid", {31'd0, bus.valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
